// File: rtl/sdu_pkg.sv
// Shared definitions for the serial debug unit: ASCII codes, digit limit and
// the command-parser state encoding.
package sdu_pkg;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [3:0] MAX_DIGITS = 4'd8;

  // Parser state encoding, kept as plain constants for legacy compatibility.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT_ARG = 3'd1;
  localparam state_t ST_ARG      = 3'd2;
  localparam state_t ST_SKIP     = 3'd3;
  localparam state_t ST_OUT      = 3'd4;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CR) || (b == LF);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h21) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/ascii2hex.sv
// Combinational ASCII-to-nibble decoder. Lower-case a-f are accepted only
// when HEX_LOWER_EN is defined.
module ascii2hex (
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (data >= 8'h30 && data <= 8'h39) begin
      nibble = data[3:0];
      is_hex = 1'b1;
    end else if (data >= 8'h41 && data <= 8'h46) begin
      nibble = data[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`ifdef HEX_LOWER_EN
    else if (data >= 8'h61 && data <= 8'h66) begin
      nibble = data[3:0] + 4'd9;
      is_hex = 1'b1;
    end
`else
    else begin
      nibble = '0;
      is_hex = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/rx_cmd_parser.sv
// Line parser for the UART debug port: "<cmd> [hex]" terminated by CR or LF.
// Optional lower-case hex digits via HEX_LOWER_EN.
module rx_cmd_parser
  import sdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d_rx,
  input  logic        vld_rx,
  output logic        rdy_rx,
  output logic [7:0]  cmd,
  output logic [31:0] word,
  output logic        has_arg,
  output logic        vld_cmd,
  input  logic        rdy_cmd,
  output logic        err
);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] nibble;
  logic       is_hex;
  logic       accept;
  logic       term;

  ascii2hex u_hex (
    .data   (d_rx),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  // Gated with rst so the upstream never sees ready while held in reset.
  assign rdy_rx  = rst && (state != ST_OUT);
  assign vld_cmd = (state == ST_OUT);
  assign accept  = vld_rx && rdy_rx;
  assign term    = is_term(d_rx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      word    <= '0;
      has_arg <= 1'b0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_printable(d_rx)) begin
            cmd   <= d_rx;
            word  <= '0;
            cnt   <= '0;
            state <= ST_WAIT_ARG;
          end
        end
        ST_WAIT_ARG: begin
          if (accept && d_rx != SPACE) begin
            if (is_hex) begin
              word  <= {word[27:0], nibble};
              cnt   <= 4'd1;
              state <= ST_ARG;
            end else if (term) begin
              has_arg <= 1'b0;
              state   <= ST_OUT;
            end else begin
              state <= ST_SKIP;
            end
          end
        end
        ST_ARG: begin
          if (accept) begin
            if (is_hex && cnt < MAX_DIGITS) begin
              word <= {word[27:0], nibble};
              cnt  <= cnt + 4'd1;
            end else if (term) begin
              has_arg <= 1'b1;
              state   <= ST_OUT;
            end else begin
              state <= ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (accept && term) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (rdy_cmd) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: directed lines push expected commands,
// a monitor pops and compares on every command transfer.
module tb_rx_cmd_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic [7:0]  cmd;
  logic [31:0] word;
  logic        has_arg;
  logic        vld_cmd;
  logic        rdy_cmd;
  logic        err;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned err_seen = 0;
  int unsigned err_exp = 0;
  logic [40:0] exp_q[$];

  rx_cmd_parser dut (
    .clk     (clk),
    .rst     (rst),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .cmd     (cmd),
    .word    (word),
    .has_arg (has_arg),
    .vld_cmd (vld_cmd),
    .rdy_cmd (rdy_cmd),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs sampled 2 time units after the falling edge.
  initial begin
    logic [40:0] e;
    logic prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (vld_cmd && rdy_cmd) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: got cmd 0x%0h word 0x%0h, expected none", cmd, word);
          end else begin
            e = exp_q.pop_front();
            check("cmd", {56'd0, cmd}, {56'd0, e[40:33]});
            check("word", {32'd0, word}, {32'd0, e[32:1]});
            check("has_arg", {63'd0, has_arg}, {63'd0, e[0]});
          end
        end
        if (err) begin
          err_seen++;
          check("err_one_cycle", {63'd0, prev_err}, 64'd0);
        end
        prev_err = err;
      end else begin
        prev_err = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    bit done;
    n = 0;
    done = 0;
    @(negedge clk);
    d_rx = b;
    vld_rx = 1'b1;
    while (!done) begin
      #1;
      if (rdy_rx) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
        n++;
        if (n > 50) begin
          tests++;
          fails++;
          $display("FAIL rx_timeout: byte 0x%0h not accepted, expected accept within 50 cycles", b);
          done = 1;
        end
      end
    end
    #1;
    vld_rx = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_exp(input logic [7:0] c, input logic [31:0] w, input logic a);
    exp_q.push_back({c, w, a});
  endtask

  task automatic settle;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    d_rx = '0;
    vld_rx = 1'b0;
    rdy_cmd = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_rdy_rx", {63'd0, rdy_rx}, 64'd0);
    check("rst_vld_cmd", {63'd0, vld_cmd}, 64'd0);
    check("rst_cmd", {56'd0, cmd}, 64'd0);
    check("rst_word", {32'd0, word}, 64'd0);
    check("rst_has_arg", {63'd0, has_arg}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_rdy_rx", {63'd0, rdy_rx}, 64'd1);

    // Basic command with argument, plus latency and single-pulse checks.
    push_exp(8'h44, 32'h0000_1A2B, 1'b1);
    send_str("D 1A2B");
    send_byte(8'h0D);
    @(negedge clk); #1;
    check("latency_vld", {63'd0, vld_cmd}, 64'd1);
    @(negedge clk); #1;
    check("single_pulse", {63'd0, vld_cmd}, 64'd0);
    settle();

    push_exp(8'h52, 32'h0, 1'b0);
    send_byte(8'h52); send_byte(8'h0A);
    push_exp(8'h52, 32'h0, 1'b0);
    send_byte(8'h52); send_byte(8'h0D); send_byte(8'h0A);
    settle();
    check("no_err_yet", {32'd0, err_seen}, {32'd0, err_exp});
    check("crlf_one_cmd", {32'd0, exp_q.size()}, 64'd0);

    // Non-printable ignored in IDLE.
    push_exp(8'h51, 32'h0, 1'b0);
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h51); send_byte(8'h0D);
    settle();

    // Nine digits overflow -> discarded line, then recovery.
    send_str("M 123456789");
    send_byte(8'h0D);
    err_exp++;
    settle();
    check("overflow_err", {32'd0, err_seen}, {32'd0, err_exp});
    push_exp(8'h53, 32'h0, 1'b0);
    send_byte(8'h53); send_byte(8'h0D);
    settle();

    // Space inside argument is malformed.
    send_str("D 1 2");
    send_byte(8'h0D);
    err_exp++;
    settle();
    check("space_in_arg_err", {32'd0, err_seen}, {32'd0, err_exp});

    // Eight digits with consumer stalled.
    rdy_cmd = 1'b0;
    push_exp(8'h50, 32'hFFFF_FFFF, 1'b1);
    send_str("P FFFFFFFF");
    send_byte(8'h0D);
    @(negedge clk);
    d_rx = 8'h58;
    vld_rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_vld", {63'd0, vld_cmd}, 64'd1);
      check("stall_word", {32'd0, word}, {32'd0, 32'hFFFF_FFFF});
      check("stall_rdy_rx", {63'd0, rdy_rx}, 64'd0);
      @(negedge clk);
    end
    rdy_cmd = 1'b1;
    push_exp(8'h58, 32'h0, 1'b0);
    send_byte(8'h58); send_byte(8'h0D);
    settle();

    // Lower-case hex digits depend on build option.
`ifdef HEX_LOWER_EN
    push_exp(8'h44, 32'h0000_00AB, 1'b1);
`else
    err_exp++;
`endif
    send_str("D ab");
    send_byte(8'h0D);
    settle();
    check("lower_hex_err", {32'd0, err_seen}, {32'd0, err_exp});

    // Reset mid-line discards the partial command.
    send_str("D 12");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midline_rst_rdy", {63'd0, rdy_rx}, 64'd0);
    check("midline_rst_vld", {63'd0, vld_cmd}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_exp(8'h49, 32'h0, 1'b0);
    send_byte(8'h49); send_byte(8'h0D);
    settle();

    check("final_err_count", {32'd0, err_seen}, {32'd0, err_exp});
    check("pending_cmds", {32'd0, exp_q.size()}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rx_cmd_parser.md
RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port d_rx  input  8  received byte from the UART receiver.
REQ-004 SHALL have port vld_rx  input  1  d_rx valid.
REQ-005 SHALL have port rdy_rx  output  1  parser can accept a byte; a byte transfers on a clk edge where vld_rx&&rdy_rx.
REQ-006 SHALL have port cmd  output  8  command character of the parsed line.
REQ-007 SHALL have port word  output  32  hex argument, zero-extended.
REQ-008 SHALL have port has_arg  output  1  line carried at least one hex digit.
REQ-009 SHALL have port vld_cmd  output  1  cmd/word/has_arg valid.
REQ-010 SHALL have port rdy_cmd  input  1  consumer (debug controller) ready; a command transfers on vld_cmd&&rdy_cmd.
REQ-011 SHALL have port err  output  1  one-cycle pulse: malformed line discarded.

Function
REQ-012 SHALL implement states IDLE, WAIT_ARG, ARG, SKIP, OUT.
REQ-013 Terminator SHALL be CR (0x0D) or LF (0x0A); space is 0x20; printable is 0x21-0x7E; hex is 0-9, A-F.
REQ-014 IDLE: space/terminator/non-printable ignored; printable -> latch cmd, clear word, clear digit count, go WAIT_ARG.
REQ-015 WAIT_ARG: space ignored; hex -> word={word[27:0],nibble}, count=1, go ARG; terminator -> go OUT with has_arg=0; other -> go SKIP.
REQ-016 ARG: hex with count<8 -> shift in nibble, count+1; hex with count=8 -> go SKIP (overflow); terminator -> go OUT with has_arg=1; other (including space) -> go SKIP.
REQ-017 SKIP: all bytes except terminator discarded; terminator -> err=1 for exactly one cycle, go IDLE; no command emitted.
REQ-018 OUT: vld_cmd=1, rdy_rx=0; cmd/word/has_arg stable until transfer; on rdy_cmd=1 -> IDLE, vld_cmd=0 the following cycle.
REQ-019 rdy_rx SHALL be 1 in every state except OUT, and 0 while rst is low.
REQ-020 vld_cmd SHALL assert on the cycle after the terminator is accepted (latency 1); if rdy_cmd is already 1, the command transfers on that first vld_cmd cycle.
REQ-021 A CR immediately followed by LF SHALL yield one command; the LF is ignored in IDLE.
REQ-022 Only bytes accepted via handshake SHALL affect state; vld_rx with rdy_rx=0 SHALL be ignored, and the byte stays with the upstream source.

Reset
REQ-023 rst low SHALL force IDLE asynchronously, including mid-line or in OUT, discarding partial or pending commands.
REQ-024 Reset values: cmd=0x00, word=0, has_arg=0, vld_cmd=0, err=0, digit count=0.

Configuration
REQ-025 With HEX_LOWER_EN defined, a-f SHALL also be hex digits (values 10-15) in WAIT_ARG/ARG; without it, a-f in those states SHALL go to SKIP.

Structure
REQ-026 Package sdu_pkg SHALL hold ASCII constants (CR, LF, SPACE), MAX_DIGITS=8, and the parser state enumeration.
REQ-027 Sub-module ascii2hex SHALL be combinational: byte in, 4-bit nibble plus is_hex out, honouring HEX_LOWER_EN.

Verification
REQ-028 Bytes "D 1A2B\r", rdy_cmd=1 -> one vld_cmd pulse; cmd=0x44, word=0x00001A2B, has_arg=1; err never set.
REQ-029 Bytes "R\n" -> cmd=0x52, word=0, has_arg=0; "R\r\n" -> exactly one command.
REQ-030 Bytes "M 123456789\r" (9 digits) -> no vld_cmd; err high for exactly one cycle when CR is accepted; next line "S\r" then parses normally.
REQ-031 Bytes "P FFFFFFFF\r" with rdy_cmd=0 for 5 cycles -> vld_cmd held, word=0xFFFFFFFF stable, rdy_rx=0 throughout; following byte accepted only after transfer.
REQ-032 Bytes "D ab\r" -> word=0xAB with HEX_LOWER_EN; err pulse and no command without it.
REQ-033 rst low after "D 12" -> next "I\r" yields cmd=0x49, word=0, has_arg=0.
